cp0_unit: RTL

Coprocessor-0 for the P7 pipelined MIPS core. Lives inside the datapath at the M stage and takes the 6-bit `HWInt` vector from the top level: `{3'b0, interrupt, timer2 IRQ, timer1 IRQ}`. Holds the SR, Cause, EPC and PRId registers. Each cycle it decides whether the M-stage instruction is the victim of an interrupt or exception. On that request the pipeline flushes and redirects to the handler; on `eret` it redirects to `EPCOut`.

---
 rtl/cp0_unit.sv | 92 +++++++++
 1 files changed

// File: rtl/cp0_unit.sv
// Coprocessor-0 for the pipelined MIPS core: SR/Cause/EPC/PRId registers plus
// the M-stage interrupt/exception request decision.
module cp0_unit #(
  parameter logic [31:0] PRID = 32'h0000_0707
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] DOut,
  output logic [31:0] EPCOut,
  output logic        Req
);

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  exc_code;
  logic [31:0] epc;

  logic int_req;
  logic exc_req;
  logic wr_sr;
  logic wr_epc;

  assign int_req = (|(HWInt & im)) & ie & ~exl;
  assign exc_req = (ExcCodeIn != 5'd0) & ~exl;
  assign Req     = int_req | exc_req;

  assign wr_sr  = WE && (A2 == REG_SR);
  assign wr_epc = WE && (A2 == REG_EPC);

  // A request squashes the victim, so its mtc0/eret side effects are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      im       <= 6'd0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ip       <= 6'd0;
      exc_code <= 5'd0;
      epc      <= 32'd0;
    end else begin
      ip <= HWInt;
      if (Req) begin
        exl      <= 1'b1;
        bd       <= BDIn;
        epc      <= BDIn ? (VPC - 32'd4) : VPC;
        exc_code <= int_req ? 5'd0 : ExcCodeIn;
      end else begin
        if (wr_sr) begin
          im  <= DIn[15:10];
          ie  <= DIn[0];
          exl <= EXLClr ? 1'b0 : DIn[1];
        end else if (EXLClr) begin
          exl <= 1'b0;
        end
        if (wr_epc) begin
          epc <= DIn;
        end
      end
    end
  end

  always_comb begin
    DOut = 32'd0;
    case (A1)
      REG_SR:    DOut = {16'd0, im, 8'd0, exl, ie};
      REG_CAUSE: DOut = {bd, 15'd0, ip, 3'd0, exc_code, 2'd0};
      REG_EPC:   DOut = epc;
      REG_PRID:  DOut = PRID;
      default:   DOut = 32'd0;
    endcase
  end

  assign EPCOut = wr_epc ? DIn : epc;

endmodule
